// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchroniser, centre sampling at a sel-selected bit
// period, valid/ack handshake, one-cycle framing and overrun pulses.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int HALF_ADJ  = 0
) (
  input  logic                 CLK,
  input  logic                 reset_external,
  input  logic [2:0]           sel,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                 r_sync1, r_sync2;
  logic [2:0]           r_state;
  logic [10:0]          r_cnt;
  logic [10:0]          r_per;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr, r_oerr;

  logic                 w_rx_s;
  logic [10:0]          w_sel_per;
  logic [10:0]          w_per_m1;
  logic [10:0]          w_half_m1;
  logic                 w_good;

  assign w_rx_s = r_sync2;

  always_comb begin
    case (sel)
      3'd0:    w_sel_per = 11'd1920;
      3'd1:    w_sel_per = 11'd960;
      3'd2:    w_sel_per = 11'd480;
      3'd3:    w_sel_per = 11'd320;
      3'd4:    w_sel_per = 11'd160;
      3'd5:    w_sel_per = 11'd80;
      3'd6:    w_sel_per = 11'd40;
      default: w_sel_per = 11'd20;
    endcase
  end

  // Terminal counts use the period latched at frame start, not the live sel.
  assign w_per_m1  = r_per - 11'd1;
  assign w_half_m1 = {1'b0, r_per[10:1]} + 11'(HALF_ADJ) - 11'd1;
  assign w_good    = (r_state == S_STOP) && (r_cnt == w_per_m1) && w_rx_s;

  always_ff @(posedge CLK or posedge reset_external) begin
    if (reset_external) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_per   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
      r_cnt   <= r_cnt + 11'd1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_per   <= w_sel_per;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == w_half_m1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (r_cnt == w_per_m1) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'(DATA_BITS-1)) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (r_cnt == w_per_m1) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_state <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // One error per low stretch: wait here until the line recovers.
          r_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase

      if (w_good) begin
        r_valid <= 1'b1;
        r_oerr  <= r_valid && !rx_ack;
      end else if (rx_ack && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_ferr;
  assign overrun_err = r_oerr;
  assign busy        = (r_state != S_IDLE);

endmodule
